// File: rtl/ap_ctrl_driver_if.sv
// ap_ctrl_hs handshake bundle between the transaction driver and an HLS kernel.
// master: the driver (issues ap_start, acknowledges with ap_continue).
// slave:  the kernel (answers with ap_ready and ap_done).
interface ap_ctrl_driver_if;
    logic ap_start;
    logic ap_ready;
    logic ap_done;
    logic ap_continue;

    modport master (
        output ap_start,
        output ap_continue,
        input  ap_ready,
        input  ap_done
    );

    modport slave (
        input  ap_start,
        input  ap_continue,
        output ap_ready,
        output ap_done
    );
endinterface

// File: rtl/ap_ctrl_driver.sv
// ap_ctrl_driver: issues a programmed number of ap_start transactions into an
// ap_ctrl_hs kernel, timestamps each accepted start in a FIFO, measures the
// latency of each retirement and raises finish when the run completes or
// aborts on an idle timeout.
// Optional feature macro: AP_CTRL_DRV_BACKPRESSURE_EN (ap_continue hold-off of
// CONT_DELAY cycles after each retire). Undefined: ap_continue is tied high.
module ap_ctrl_driver #(
    parameter int unsigned NUM_TRANS_W = 16,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned TIMEOUT     = 100000,
    parameter int unsigned CONT_DELAY  = 3
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   run,
    input  logic [NUM_TRANS_W-1:0] num_trans,
    ap_ctrl_driver_if.master       ctrl,
    output logic                   finish,
    output logic                   timeout_err,
    output logic                   proto_err,
    output logic [NUM_TRANS_W-1:0] started_cnt,
    output logic [NUM_TRANS_W-1:0] done_cnt,
    output logic [CNT_W-1:0]       last_lat,
    output logic [CNT_W-1:0]       max_lat,
    output logic                   lat_valid
);

    localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned OCC_W  = PTR_W + 1;
    localparam int unsigned IDLE_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int unsigned CD_W   = (CONT_DELAY > 0) ? $clog2(CONT_DELAY + 1) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE,
        ST_TOUT
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cyc_q;
    logic [NUM_TRANS_W-1:0] num_q;
    logic [NUM_TRANS_W-1:0] started_q, started_d;
    logic [NUM_TRANS_W-1:0] done_q, done_d;
    logic [CNT_W-1:0]       last_lat_q, max_lat_q, lat_d;
    logic                   lat_valid_q;
    logic                   proto_q;
    logic                   start_q, start_d;
    logic                   cont_q;

    logic [CNT_W-1:0]       mem [DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
    logic [OCC_W-1:0]       occ_q, occ_d;
    logic [IDLE_W-1:0]      idle_q, idle_d;

    logic accept, retire, load, fifo_empty;
    logic bypass, push, pop, spurious;

    // Handshake decode, FIFO bookkeeping, next state and next ap_start
    always_comb begin
        accept     = start_q & ctrl.ap_ready;
        retire     = ctrl.ap_done & cont_q;
        load       = run && (state_q == ST_IDLE || state_q == ST_DONE || state_q == ST_TOUT);
        fifo_empty = (occ_q == '0);
        // An accept and retire in the same cycle with nothing outstanding
        // retires the very transaction being started: no FIFO traffic.
        bypass     = accept & retire & fifo_empty;
        push       = accept & ~bypass;
        pop        = retire & ~fifo_empty;
        spurious   = retire & fifo_empty & ~accept;

        occ_d      = occ_q + OCC_W'(push) - OCC_W'(pop);
        started_d  = started_q + NUM_TRANS_W'(accept);
        done_d     = done_q + NUM_TRANS_W'(pop | bypass);
        lat_d      = bypass ? '0 : (cyc_q - mem[rd_ptr_q]);

        idle_d = idle_q;
        if (retire) begin
            idle_d = '0;
        end else if ((state_q == ST_RUN || state_q == ST_DRAIN) && !fifo_empty) begin
            idle_d = idle_q + IDLE_W'(1);
        end

        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_TOUT: begin
                if (run) begin
                    state_d = (num_trans == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN, ST_DRAIN: begin
                if (idle_d >= IDLE_W'(TIMEOUT)) begin
                    state_d = ST_TOUT;
                end else if (done_d == num_q) begin
                    state_d = ST_DONE;
                end else if (state_q == ST_RUN && started_d == num_q) begin
                    state_d = ST_DRAIN;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // ap_start is computed from the post-edge view so it rises with the
        // entry into RUN and drops together with leaving it.
        if (load) begin
            start_d = (state_d == ST_RUN);
        end else begin
            start_d = (state_d == ST_RUN) && (started_d < num_q) && (occ_d < OCC_W'(DEPTH));
        end
    end

    // Free-running cycle counter used as the timestamp base
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cyc_q <= '0;
        end else begin
            cyc_q <= cyc_q + CNT_W'(1);
        end
    end

    // Control state and registered ap_start
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
        end
    end

    // Timestamp storage: the cycle count at each accepted start
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr_q] <= cyc_q;
        end
    end

    // FIFO pointers, occupancy and idle timer; flushed when a run is loaded
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            idle_q   <= '0;
        end else if (load) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            idle_q   <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            occ_q  <= occ_d;
            idle_q <= idle_d;
        end
    end

    // Run statistics: counts, latency capture and protocol error flag
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            num_q       <= '0;
            started_q   <= '0;
            done_q      <= '0;
            last_lat_q  <= '0;
            max_lat_q   <= '0;
            lat_valid_q <= 1'b0;
            proto_q     <= 1'b0;
        end else if (load) begin
            num_q       <= num_trans;
            started_q   <= '0;
            done_q      <= '0;
            max_lat_q   <= '0;
            lat_valid_q <= 1'b0;
            proto_q     <= 1'b0;
        end else begin
            started_q   <= started_d;
            done_q      <= done_d;
            lat_valid_q <= pop | bypass;
            if (pop | bypass) begin
                last_lat_q <= lat_d;
                if (lat_d > max_lat_q) begin
                    max_lat_q <= lat_d;
                end
            end
            if (spurious) begin
                proto_q <= 1'b1;
            end
        end
    end

`ifdef AP_CTRL_DRV_BACKPRESSURE_EN
    logic [CD_W-1:0] cont_cnt_q;

    // ap_continue hold-off: low for CONT_DELAY cycles after reset and after each retire
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cont_q     <= 1'b0;
            cont_cnt_q <= CD_W'(CONT_DELAY);
        end else if (retire && CONT_DELAY != 0) begin
            cont_q     <= 1'b0;
            cont_cnt_q <= CD_W'(CONT_DELAY);
        end else begin
            if (cont_cnt_q != '0) begin
                cont_cnt_q <= cont_cnt_q - CD_W'(1);
            end
            cont_q <= (cont_cnt_q <= CD_W'(1));
        end
    end
`else
    // Every done is acknowledged immediately; CD_W is always non-zero.
    assign cont_q = (CD_W != 0);
`endif

    assign ctrl.ap_start    = start_q;
    assign ctrl.ap_continue = cont_q;
    assign finish           = (state_q == ST_DONE) || (state_q == ST_TOUT);
    assign timeout_err      = (state_q == ST_TOUT);
    assign proto_err        = proto_q;
    assign started_cnt      = started_q;
    assign done_cnt         = done_q;
    assign last_lat         = last_lat_q;
    assign max_lat          = max_lat_q;
    assign lat_valid        = lat_valid_q;

endmodule
